// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one Ready-handshaked memory between I and D ports; define ARB_ROUND_ROBIN_EN for round-robin, else D wins contention.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic        IReady,
  output logic [31:0] IRD,
  input  logic        DReq,
  input  logic        DWE,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWD,
  output logic        DReady,
  output logic [31:0] DRD,
  output logic        Err,
  output logic        MemReq,
  output logic        MemWE,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWD,
  input  logic        MemReady,
  input  logic [31:0] MemRD
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_n;
  logic owner, owner_n, last, last_n, win, mreq_n, mwe_n, irdy_n, drdy_n, err_n;
  logic [7:0] cnt, cnt_n, cnt_inc;
  logic [31:0] maddr_n, mwd_n, ird_n, drd_n, rd;
  always_comb begin
    cnt_inc = (cnt == 8'hff) ? cnt : cnt + 8'd1;
`ifdef ARB_ROUND_ROBIN_EN
    win = (IReq & DReq) ? ~last : DReq;
`else
    win = DReq;
`endif
    rd = (MemReady & ~MemWE) ? MemRD : '0;
    state_n = state;
    owner_n = owner;
    last_n = last;
    cnt_n = cnt;
    mreq_n = MemReq;
    mwe_n = MemWE;
    maddr_n = MemAddr;
    mwd_n = MemWD;
    ird_n = IRD;
    drd_n = DRD;
    irdy_n = 1'b0;
    drdy_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: if (IReq | DReq) begin
        state_n = BUSY;
        owner_n = win;
        last_n = win;
        cnt_n = '0;
        mreq_n = 1'b1;
        mwe_n = win & DWE;
        maddr_n = win ? DAddr : IAddr;
        mwd_n = win ? DWD : '0;
      end
      BUSY: begin
        cnt_n = cnt_inc;
        if (MemReady | (cnt_inc == 8'(TIMEOUT))) begin
          state_n = RESP;
          mreq_n = 1'b0;
          irdy_n = ~owner;
          drdy_n = owner;
          err_n = ~MemReady;
          ird_n = owner ? IRD : rd;
          drd_n = owner ? rd : DRD;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      owner <= 1'b0;
      last <= 1'b1;
      cnt <= '0;
      MemReq <= 1'b0;
      MemWE <= 1'b0;
      MemAddr <= '0;
      MemWD <= '0;
      IRD <= '0;
      DRD <= '0;
      IReady <= 1'b0;
      DReady <= 1'b0;
      Err <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last <= last_n;
      cnt <= cnt_n;
      MemReq <= mreq_n;
      MemWE <= mwe_n;
      MemAddr <= maddr_n;
      MemWD <= mwd_n;
      IRD <= ird_n;
      DRD <= drd_n;
      IReady <= irdy_n;
      DReady <= drdy_n;
      Err <= err_n;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized bench for mem_arbiter against a transaction-level model and a latency-programmable memory.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int TMO = 4;
  logic CLK = 1'b0, Reset = 1'b1;
  logic IReq = 1'b0, DReq = 1'b0, DWE = 1'b0, MemReady = 1'b0;
  logic [31:0] IAddr = '0, DAddr = '0, DWD = '0, MemRD = '0;
  logic IReady, DReady, Err, MemReq, MemWE;
  logic [31:0] IRD, DRD, MemAddr, MemWD;
  int checks = 0, failures = 0;
  int lat = 0, spur_req = 0, spur_done = 0, mk = 0;
  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];
  logic m_last;
  logic [31:0] m_ird, m_drd;
  int cyc, mreq_cycles;
  logic f_mreq, f_mwe, g_i, g_d, g_e;
  logic [31:0] f_maddr, f_mwd, g_ird, g_drd;

  mem_arbiter #(.TIMEOUT(TMO)) dut (
    .CLK(CLK), .Reset(Reset),
    .IReq(IReq), .IAddr(IAddr), .IReady(IReady), .IRD(IRD),
    .DReq(DReq), .DWE(DWE), .DAddr(DAddr), .DWD(DWD), .DReady(DReady), .DRD(DRD),
    .Err(Err), .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr), .MemWD(MemWD),
    .MemReady(MemReady), .MemRD(MemRD)
  );

  initial forever #5 CLK = ~CLK;

  // Memory answers after `lat` wait cycles of MemReq (never when lat < 0)
  initial forever begin
    @(negedge CLK);
    MemReady = 1'b0;
    if (Reset) mk = 0;
    else if (spur_req != spur_done) begin
      spur_done = spur_req;
      MemReady = 1'b1;
      MemRD = $urandom;
    end else if (!MemReq) mk = 0;
    else begin
      if (lat >= 0 && mk == lat) begin
        MemReady = 1'b1;
        MemRD = MemWE ? $urandom : mem[MemAddr[7:2]];
        if (MemWE) mem[MemAddr[7:2]] = MemWD;
      end
      mk++;
    end
  end

  function automatic int exp_cyc(int l);
    return (l < 0 || l >= TMO) ? TMO + 1 : l + 2;
  endfunction

  function automatic logic exp_win(logic i, logic d);
`ifdef ARB_ROUND_ROBIN_EN
    return (i && d) ? !m_last : d;
`else
    return d;
`endif
  endfunction

  task automatic wait_ready();
    cyc = -1;
    mreq_cycles = 0;
    for (int i = 1; i <= 64 && cyc < 0; i++) begin
      @(negedge CLK);
      if (i == 1) begin
        f_mreq = MemReq; f_mwe = MemWE; f_maddr = MemAddr; f_mwd = MemWD;
      end
      mreq_cycles += int'(MemReq);
      if (IReady || DReady) begin
        cyc = i; g_i = IReady; g_d = DReady; g_e = Err; g_ird = IRD; g_drd = DRD;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; IReq = 1'b0; DReq = 1'b0; DWE = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if ({MemReq, MemWE, IReady, DReady, Err} !== 5'b0) begin
      failures++; $display("FAIL reset_ctl got=%b exp=00000", {MemReq, MemWE, IReady, DReady, Err});
    end
    checks++;
    if ({MemAddr, MemWD, IRD, DRD} !== 128'b0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {MemAddr, MemWD, IRD, DRD});
    end
    Reset = 1'b0;
    m_last = 1'b1; m_ird = '0; m_drd = '0;
  endtask

  task automatic test_single_fetch();
    mem[2] = 32'h2008_0005; ref_mem[2] = 32'h2008_0005; lat = 3;
    IAddr = 32'h8; IReq = 1'b1;
    wait_ready();
    checks++;
    if ({f_mreq, f_mwe, f_maddr, f_mwd} !== {1'b1, 1'b0, 32'h8, 32'h0}) begin
      failures++; $display("FAIL fetch_issue got req=%b we=%b addr=%h wd=%h exp 1 0 8 0", f_mreq, f_mwe, f_maddr, f_mwd);
    end
    checks++;
    if (cyc !== 5) begin failures++; $display("FAIL fetch_latency got=%0d exp=5", cyc); end
    checks++;
    if ({g_i, g_d, g_e, g_ird} !== {3'b100, 32'h2008_0005}) begin
      failures++; $display("FAIL fetch_resp got i=%b d=%b e=%b ird=%h exp 1 0 0 20080005", g_i, g_d, g_e, g_ird);
    end
    IReq = 1'b0;
    @(negedge CLK);
    checks++;
    if (IReady !== 1'b0) begin failures++; $display("FAIL fetch_pulse got=%b exp=0", IReady); end
  endtask

  task automatic test_write_read();
    lat = $urandom_range(0, 3);
    DWE = 1'b1; DAddr = 32'h54; DWD = 32'h7; DReq = 1'b1;
    wait_ready();
    checks++;
    if ({f_mwe, f_maddr, f_mwd} !== {1'b1, 32'h54, 32'h7}) begin
      failures++; $display("FAIL write_issue got we=%b addr=%h wd=%h exp 1 54 7", f_mwe, f_maddr, f_mwd);
    end
    checks++;
    if (cyc !== lat + 2 || {g_i, g_d, g_e, g_drd} !== {3'b010, 32'h0}) begin
      failures++; $display("FAIL write_resp got cyc=%0d i=%b d=%b e=%b drd=%h exp %0d 0 1 0 0", cyc, g_i, g_d, g_e, g_drd, lat + 2);
    end
    DReq = 1'b0; ref_mem[21] = 32'h7;
    @(negedge CLK);
    lat = $urandom_range(0, 3);
    DWE = 1'b0; DReq = 1'b1;
    wait_ready();
    checks++;
    if ({f_mwe, g_d, g_e, g_drd} !== {3'b010, ref_mem[21]}) begin
      failures++; $display("FAIL read_back got we=%b d=%b e=%b drd=%h exp 0 1 0 %h", f_mwe, g_d, g_e, g_drd, ref_mem[21]);
    end
    DReq = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_contention();
    logic ed;
    test_reset();
    IAddr = 32'h10; DAddr = 32'h24; DWE = 1'b0; IReq = 1'b1; DReq = 1'b1;
    for (int g = 0; g < 3; g++) begin
      lat = $urandom_range(0, 3);
      ed = exp_win(1'b1, 1'b1);
      wait_ready();
      checks++;
      if ({g_i, g_d, f_maddr} !== {!ed, ed, ed ? 32'h24 : 32'h10} || cyc !== lat + 2) begin
        failures++; $display("FAIL contention_grant%0d got i=%b d=%b addr=%h cyc=%0d exp d=%b cyc=%0d", g, g_i, g_d, f_maddr, cyc, ed, lat + 2);
      end
      checks++;
      if ((ed ? g_drd : g_ird) !== ref_mem[ed ? 9 : 4]) begin
        failures++; $display("FAIL contention_data%0d got=%h exp=%h", g, ed ? g_drd : g_ird, ref_mem[ed ? 9 : 4]);
      end
      m_last = ed;
      @(negedge CLK);
    end
    IReq = 1'b0; DReq = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_timeout();
    lat = -1; DWE = 1'b0; DAddr = 32'h30; DReq = 1'b1;
    wait_ready();
    checks++;
    if (cyc !== TMO + 1 || mreq_cycles !== TMO) begin
      failures++; $display("FAIL timeout_len got cyc=%0d mreq=%0d exp %0d %0d", cyc, mreq_cycles, TMO + 1, TMO);
    end
    checks++;
    if ({g_i, g_d, g_e, g_drd} !== {3'b011, 32'h0}) begin
      failures++; $display("FAIL timeout_resp got i=%b d=%b e=%b drd=%h exp 0 1 1 0", g_i, g_d, g_e, g_drd);
    end
    DReq = 1'b0;
    @(negedge CLK);
    checks++;
    if ({Err, DReady, MemReq} !== 3'b0) begin failures++; $display("FAIL timeout_pulse got=%b exp=000", {Err, DReady, MemReq}); end
    lat = TMO - 1; IAddr = 32'h8; IReq = 1'b1;
    wait_ready();
    checks++;
    if (cyc !== TMO + 1 || {g_i, g_e, g_ird} !== {2'b10, ref_mem[2]}) begin
      failures++; $display("FAIL timeout_edge got cyc=%0d i=%b e=%b ird=%h exp %0d 1 0 %h", cyc, g_i, g_e, g_ird, TMO + 1, ref_mem[2]);
    end
    IReq = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    int seen;
    lat = -1; IAddr = 32'h8; IReq = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (MemReq !== 1'b1) begin failures++; $display("FAIL midreset_busy got=%b exp=1", MemReq); end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({MemReq, MemWE, IReady, DReady, Err, MemAddr, IRD} !== 69'b0) begin
      failures++; $display("FAIL midreset_async got req=%b addr=%h ird=%h exp 0", MemReq, MemAddr, IRD);
    end
    IReq = 1'b0;
    @(negedge CLK);
    Reset = 1'b0; m_last = 1'b1; m_ird = '0; m_drd = '0;
    spur_req++;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      seen += int'(IReady | DReady | Err | MemReq);
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL midreset_spurious got=%0d exp=0", seen); end
  endtask

  task automatic test_stale();
    lat = $urandom_range(0, 3); IAddr = 32'h40; IReq = 1'b1;
    wait_ready();
    checks++;
    if ({g_i, g_ird} !== {1'b1, ref_mem[16]}) begin
      failures++; $display("FAIL stale_first got i=%b ird=%h exp 1 %h", g_i, g_ird, ref_mem[16]);
    end
    IAddr = 32'h44;
    @(negedge CLK);
    checks++;
    if (MemReq !== 1'b0) begin failures++; $display("FAIL stale_regrant got=%b exp=0", MemReq); end
    lat = $urandom_range(0, 3);
    wait_ready();
    checks++;
    if (f_maddr !== 32'h44 || cyc !== lat + 2 || g_ird !== ref_mem[17]) begin
      failures++; $display("FAIL stale_second got addr=%h cyc=%0d ird=%h exp 44 %0d %h", f_maddr, cyc, g_ird, lat + 2, ref_mem[17]);
    end
    IReq = 1'b0;
    @(negedge CLK);
    m_last = 1'b0; m_ird = ref_mem[17];
  endtask

  task automatic test_random();
    logic i, d, w, ed, to;
    int l;
    logic [31:0] ia, da, wd, erd;
    for (int t = 0; t < 40; t++) begin
      i = 1'($urandom); d = 1'($urandom); w = 1'($urandom);
      if (!i && !d) d = 1'b1;
      ia = {24'h0, 6'($urandom), 2'b00};
      da = {24'h0, 6'($urandom), 2'b00};
      wd = $urandom;
      if ($urandom_range(0, 5) == 0) l = -1;
      else l = int'($urandom_range(0, TMO));
      lat = l; IAddr = ia; IReq = i; DAddr = da; DWE = w; DWD = wd; DReq = d;
      ed = exp_win(i, d);
      to = (l < 0 || l >= TMO);
      erd = (to || (ed && w)) ? 32'h0 : ref_mem[ed ? da[7:2] : ia[7:2]];
      wait_ready();
      checks++;
      if (cyc !== exp_cyc(l) || {g_i, g_d, g_e} !== {!ed, ed, to}) begin
        failures++; $display("FAIL rand%0d_resp got cyc=%0d i=%b d=%b e=%b exp %0d %b %b %b", t, cyc, g_i, g_d, g_e, exp_cyc(l), !ed, ed, to);
      end
      checks++;
      if ({f_maddr, f_mwe, f_mwd} !== {ed ? da : ia, ed & w, ed ? wd : 32'h0}) begin
        failures++; $display("FAIL rand%0d_issue got addr=%h we=%b wd=%h exp %h %b %h", t, f_maddr, f_mwe, f_mwd, ed ? da : ia, ed & w, ed ? wd : 32'h0);
      end
      checks++;
      if ({g_ird, g_drd} !== (ed ? {m_ird, erd} : {erd, m_drd})) begin
        failures++; $display("FAIL rand%0d_data got ird=%h drd=%h exp %h", t, g_ird, g_drd, ed ? {m_ird, erd} : {erd, m_drd});
      end
      m_last = ed;
      if (ed) m_drd = erd;
      else m_ird = erd;
      if (ed && w && !to) ref_mem[da[7:2]] = wd;
      IReq = 1'b0; DReq = 1'b0;
      @(negedge CLK);
      checks++;
      if ({IReady, DReady, Err} !== 3'b0) begin failures++; $display("FAIL rand%0d_pulse got=%b exp=000", t, {IReady, DReady, Err}); end
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
  endtask

  initial begin
    for (int k = 0; k < 64; k++) begin
      mem[k] = $urandom | 32'h1;
      ref_mem[k] = mem[k];
    end
    test_reset();
    test_single_fetch();
    test_write_read();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_stale();
    test_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
